// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that reuses one external 4-bit ripple-carry adder,
// feeding it one nibble per cycle LSB-first and chaining the carry in a register.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [3:0]       rca_A,
   output logic [3:0]       rca_B,
   output logic             rca_Cin,
   input  logic [3:0]       rca_Sum,
   input  logic             rca_Cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry;
   logic [IW-1:0]    idx;
   logic             valid_q;
   logic             busy_q;
   logic             ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= in_a;
                  b_reg   <= in_b;
                  carry   <= in_cin;
                  idx     <= '0;
                  sum_reg <= '0;
                  state   <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               // The adder result for the current nibble is folded in on every RUN edge.
               sum_reg[idx*4 +: 4] <= rca_Sum;
               carry               <= rca_Cout;
               if (idx == LAST_IDX) begin
                  idx     <= '0;
                  state   <= DONE;
                  valid_q <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Adder inputs come only from registers and are parked at zero outside RUN.
   assign rca_A   = (state == RUN) ? a_reg[idx*4 +: 4] : 4'h0;
   assign rca_B   = (state == RUN) ? b_reg[idx*4 +: 4] : 4'h0;
   assign rca_Cin = (state == RUN) ? carry : 1'b0;

   assign in_ready  = ready_q;
   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_sum   = valid_q ? sum_reg : '0;
   assign out_cout  = valid_q & carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder with a behavioural
// 4-bit adder on the rca_* port and a plain-arithmetic reference model.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             in_cin = 1'b0;
   logic [3:0]       rca_A;
   logic [3:0]       rca_B;
   logic             rca_Cin;
   logic [3:0]       rca_Sum;
   logic             rca_Cout;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] exp_a;
   logic [WIDTH-1:0] exp_b;
   logic             exp_cin;

   always #5 clk = ~clk;

   // Behavioural 4-bit ripple-carry adder on the time-shared port.
   assign {rca_Cout, rca_Sum} = 5'(rca_A) + 5'(rca_B) + 5'(rca_Cin);

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .rca_A    (rca_A),
      .rca_B    (rca_B),
      .rca_Cin  (rca_Cin),
      .rca_Sum  (rca_Sum),
      .rca_Cout (rca_Cout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic c);
      return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
   endfunction

   // Carry entering nibble k: what the low 4k bits overflow into bit 4k.
   function automatic logic carry_into(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic c, input int k);
      logic [WIDTH:0] mask;
      logic [WIDTH:0] s;
      mask = ((WIDTH+1)'(1) << (4*k)) - 1;
      s    = ((WIDTH+1)'(a) & mask) + ((WIDTH+1)'(b) & mask) + (WIDTH+1)'(c);
      return s[4*k];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      exp_a    = a;
      exp_b    = b;
      exp_cin  = c;
      tick();
      in_valid = 1'b0;
      in_a     = WIDTH'($urandom);
      in_b     = WIDTH'($urandom);
      in_cin   = 1'($urandom);
   endtask

   task automatic finish_op(input string tag);
      logic [WIDTH:0] r;
      r = ref_sum(exp_a, exp_b, exp_cin);
      for (int k = 0; k < NIB; k++) begin
         chk({tag, "_run_valid"}, 32'(out_valid), 32'd0);
         chk({tag, "_run_busy"}, 32'(busy), 32'd1);
         chk({tag, "_rca_a"}, 32'(rca_A), 32'((exp_a >> (4*k)) & 'hF));
         chk({tag, "_rca_b"}, 32'(rca_B), 32'((exp_b >> (4*k)) & 'hF));
         chk({tag, "_rca_cin"}, 32'(rca_Cin), 32'(carry_into(exp_a, exp_b, exp_cin, k)));
         tick();
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(out_sum), 32'(r[WIDTH-1:0]));
      chk({tag, "_cout"}, 32'(out_cout), 32'(r[WIDTH]));
      chk({tag, "_done_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_done_rca"}, 32'(rca_A), 32'd0);
   endtask

   task automatic release_op(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] q_a[$];
      logic [WIDTH-1:0] q_b[$];
      logic             q_c[$];
      logic [WIDTH:0]   r;
      logic [WIDTH-1:0] held_sum;
      logic             held_cout;
      int sent, recv, cyc, last_rise;
      logic prev_ov;

      #12;
      rst_n = 1'b1;
      tick();
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_cout", 32'(out_cout), 32'd0);
      chk("rst_rca", 32'({rca_A, rca_B, rca_Cin}), 32'd0);

      start_op(16'h1234, 16'h4321, 1'b0); finish_op("basic");  release_op("basic");
      start_op(16'hFFFF, 16'h0001, 1'b0); finish_op("chain");  release_op("chain");
      start_op(16'hFFFF, 16'h0000, 1'b1); finish_op("cin_ff"); release_op("cin_ff");
      start_op(16'h0000, 16'h0000, 1'b1); finish_op("cin_00"); release_op("cin_00");

      // Backpressure: result must hold while the producer side is noisy.
      start_op(16'h1234, 16'h0FF0, 1'b0);
      finish_op("bp");
      held_sum  = out_sum;
      held_cout = out_cout;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         in_a     = WIDTH'($urandom);
         tick();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_sum", 32'(out_sum), 32'(held_sum));
         chk("bp_cout", 32'(out_cout), 32'(held_cout));
         chk("bp_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b1;
      in_a      = 16'h00FF;
      in_b      = 16'h0F01;
      in_cin    = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_rel_valid", 32'(out_valid), 32'd0);
      chk("bp_rel_busy", 32'(busy), 32'd0);
      start_op(16'h00FF, 16'h0F01, 1'b1); finish_op("bp_next"); release_op("bp_next");

      // Reset in the middle of RUN discards the operation.
      start_op(16'hAAAA, 16'h5555, 1'b0);
      tick();
      tick();
      chk("mid_rca_a", 32'(rca_A), 32'hA);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sum", 32'(out_sum), 32'd0);
      chk("mid_rst_rca", 32'({rca_A, rca_B, rca_Cin}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      start_op(16'h8000, 16'h8000, 1'b0); finish_op("post_rst"); release_op("post_rst");

      // Back-to-back random stream with both handshakes held open.
      sent      = 0;
      recv      = 0;
      cyc       = 0;
      last_rise = -1;
      prev_ov   = 1'b0;
      out_ready = 1'b1;
      while (recv < 50 && cyc < 2000) begin
         if (out_valid) begin
            if (q_a.size() == 0) begin
               chk("b2b_unexpected", 32'd1, 32'd0);
            end else begin
               r = ref_sum(q_a.pop_front(), q_b.pop_front(), q_c.pop_front());
               chk("b2b_sum", 32'(out_sum), 32'(r[WIDTH-1:0]));
               chk("b2b_cout", 32'(out_cout), 32'(r[WIDTH]));
            end
            if (!prev_ov) begin
               if (last_rise >= 0) chk("b2b_spacing", 32'(cyc - last_rise), 32'(NIB + 2));
               last_rise = cyc;
            end
            recv++;
         end
         prev_ov = out_valid;
         if (sent < 50) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            in_cin   = 1'($urandom);
            if (in_ready) begin
               q_a.push_back(in_a);
               q_b.push_back(in_b);
               q_c.push_back(in_cin);
               sent++;
            end
         end else begin
            in_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      chk("b2b_count", 32'(recv), 32'd50);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
